// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment display bus reader.
//   - SEG_0..SEG_F : active-low glyph patterns (bit0=a .. bit6=g)
//   - SEG_BLANK    : all segments off
//   - state_t      : frame state (COLLECT, HOLD)
//   - clog2()      : bit width needed to count 0..v-1 (minimum 1)
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/seg7_capture_if.sv
// seg7_capture_if: display bus in, assembled word out with valid/ack.
//   master : display driver + word consumer (drives seg7_in, dig_sel, ack_in)
//   slave  : the capture block (drives value_out, err_out, valid_out)
interface seg7_capture_if #(
    parameter int NDIG = 2
);
    logic [6:0]        seg7_in;
    logic [NDIG-1:0]   dig_sel;
    logic              ack_in;
    logic [4*NDIG-1:0] value_out;
    logic [NDIG-1:0]   err_out;
    logic              valid_out;

    modport master (
        output seg7_in, dig_sel, ack_in,
        input  value_out, err_out, valid_out
    );

    modport slave (
        input  seg7_in, dig_sel, ack_in,
        output value_out, err_out, valid_out
    );
endinterface

// File: rtl/seg7_to_binary.sv
// seg7_to_binary: combinational glyph decoder.
//   seg     : active-low segment pattern
//   nibble  : hex value of the glyph (0 when not a glyph)
//   invalid : pattern is none of the 16 hex glyphs (blank included)
module seg7_to_binary (
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       invalid
);
    import seg7_pkg::*;

    always_comb begin
        nibble  = 4'h0;
        invalid = 1'b0;
        case (seg)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: invalid = 1'b1;
        endcase
    end
endmodule

// File: rtl/seg7_capture.sv
// seg7_capture: reads a multiplexed 7-segment display bus back into a word.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : seg7_capture_if.slave
//              in : seg7_in (active-low segments), dig_sel (one-hot), ack_in
//              out: value_out (digit i at [4i+3:4i]), err_out, valid_out
// A {dig_sel, seg7_in} pair must be seen at STABLE_CYC consecutive edges
// before it is committed into its digit slot. Once every digit has been
// committed the slots are copied to the outputs and held until ack_in.
module seg7_capture #(
    parameter int NDIG       = 2,
    parameter int STABLE_CYC = 4
) (
    input  logic         clk,
    input  logic         rst,
    seg7_capture_if.slave bus
);
    import seg7_pkg::*;

    localparam int             CNT_W   = clog2(STABLE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYC - 2);

    logic [6:0]            samp_seg;
    logic [NDIG-1:0]       samp_sel;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic                  same, commit;
    logic [3:0]            dec_nib;
    logic                  dec_bad;
    logic [NDIG-1:0][3:0]  slot;
    logic [NDIG-1:0]       err_slot, captured;
    logic [4*NDIG-1:0]     value_q;
    logic [NDIG-1:0]       err_q;
    logic                  valid_q;
    state_t                state, state_nxt;
    logic                  xfer, do_ack;

    // Decode the registered sample; at a commit edge it equals the input.
    seg7_to_binary u_dec (
        .seg     (samp_seg),
        .nibble  (dec_nib),
        .invalid (dec_bad)
    );

    always_comb begin
        same    = ({bus.dig_sel, bus.seg7_in} == {samp_sel, samp_seg});
        cnt_nxt = '0;
        if (same)
            cnt_nxt = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
        // Only the edge that takes the counter into saturation commits, so
        // a long stable run produces exactly one commit.
        commit = same && (cnt == CNT_PRE) && $onehot(samp_sel);
    end

    always_comb begin
        state_nxt = state;
        xfer      = 1'b0;
        do_ack    = 1'b0;
        case (state)
            COLLECT: begin
                if (&captured) begin
                    state_nxt = HOLD;
                    xfer      = 1'b1;
                end
            end
            HOLD: begin
                if (bus.ack_in) begin
                    state_nxt = COLLECT;
                    do_ack    = 1'b1;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= COLLECT;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_seg <= '0;
            samp_sel <= '0;
            cnt      <= '0;
            slot     <= '0;
            err_slot <= '0;
            captured <= '0;
            value_q  <= '0;
            err_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            samp_seg <= bus.seg7_in;
            samp_sel <= bus.dig_sel;
            cnt      <= cnt_nxt;

            if (xfer) begin
                value_q  <= slot;
                err_q    <= err_slot;
                valid_q  <= 1'b1;
                captured <= '0;
            end else if (do_ack) begin
                valid_q <= 1'b0;
            end

            // A commit on the transfer edge belongs to the next frame, so it
            // is applied after the clear above.
            for (int i = 0; i < NDIG; i++) begin
                if (commit && samp_sel[i]) begin
                    slot[i]     <= dec_nib;
                    err_slot[i] <= dec_bad;
                    captured[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.value_out = value_q;
    assign bus.err_out   = err_q;
    assign bus.valid_out = valid_q;

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed and randomized checks of seg7_capture against a
// frame-level reference model (run lengths, glyph lookup, frame/hold flags).
module tb_seg7_capture;
    localparam int NDIG       = 2;
    localparam int STABLE_CYC = 4;

    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg7_capture_if #(.NDIG(NDIG)) vif ();

    seg7_capture #(.NDIG(NDIG), .STABLE_CYC(STABLE_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif.slave)
    );

    int nvec  = 0;
    int nfail = 0;

    // Reference model state
    logic [NDIG+6:0]   m_prev;
    int                m_run;
    logic [3:0]        m_slot [NDIG];
    bit                m_serr [NDIG];
    bit                m_capt [NDIG];
    bit                m_hold;
    logic [4*NDIG-1:0] m_value;
    logic [NDIG-1:0]   m_err_out;
    logic              m_valid;

    function automatic void decode(input logic [6:0] p, output logic [3:0] n, output bit bad);
        n   = 4'h0;
        bad = 1'b1;
        for (int k = 0; k < 16; k++)
            if (GLYPH[k] == p) begin
                n   = k[3:0];
                bad = 1'b0;
            end
    endfunction

    task automatic model_edge();
        logic [NDIG+6:0] pair;
        logic [NDIG-1:0] sel;
        int              hit;
        bit              full;
        logic [3:0]      n;
        bit              bad;
        pair = {vif.dig_sel, vif.seg7_in};
        sel  = vif.dig_sel;
        if (rst) begin
            m_prev = '0; m_run = 1; m_hold = 0;
            m_value = '0; m_err_out = '0; m_valid = 0;
            for (int k = 0; k < NDIG; k++) begin
                m_slot[k] = 0; m_serr[k] = 0; m_capt[k] = 0;
            end
            return;
        end
        if (pair == m_prev) m_run++;
        else begin m_run = 1; m_prev = pair; end
        hit = -1;
        if (m_run == STABLE_CYC && $onehot(sel))
            for (int k = 0; k < NDIG; k++) if (sel[k]) hit = k;
        full = 1;
        for (int k = 0; k < NDIG; k++) full &= m_capt[k];
        if (!m_hold && full) begin
            for (int k = 0; k < NDIG; k++) begin
                m_value[4*k +: 4] = m_slot[k];
                m_err_out[k]      = m_serr[k];
                m_capt[k]         = 0;
            end
            m_valid = 1; m_hold = 1;
        end else if (m_hold && vif.ack_in) begin
            m_hold = 0; m_valid = 0;
        end
        if (hit >= 0) begin
            decode(vif.seg7_in, n, bad);
            m_slot[hit] = n; m_serr[hit] = bad; m_capt[hit] = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic [NDIG-1:0] sel, input logic [6:0] seg);
        vif.dig_sel = sel;
        vif.seg7_in = seg;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vif.ack_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) rst = 1'b0;
            drive(NDIG'($urandom), 7'($urandom));
            if (c == 2) drive('0, 7'h7f);
            step();
            nvec++;
            if ({vif.value_out, vif.err_out, vif.valid_out} !== '0) begin
                nfail++;
                $display("FAIL reset c%0d: value=%h err=%b valid=%b, expected 00 00 0",
                         c, vif.value_out, vif.err_out, vif.valid_out);
            end
        end
    endtask

    task automatic test_basic_frame();
        drive('0, 7'h7f);
        repeat (2) step();
        drive(2'b01, GLYPH[3]);
        repeat (STABLE_CYC) step();
        drive(2'b10, GLYPH[1]);
        for (int c = 0; c <= STABLE_CYC; c++) begin
            step();
            nvec++;
            if (vif.valid_out !== (c == STABLE_CYC)) begin
                nfail++;
                $display("FAIL basic_latency edge%0d: valid=%b, expected %b",
                         c + 1, vif.valid_out, c == STABLE_CYC);
            end
        end
        nvec++;
        if (vif.value_out !== 8'h13 || vif.err_out !== 2'b00 || vif.value_out !== m_value) begin
            nfail++;
            $display("FAIL basic_value: value=%h err=%b, expected 13 00", vif.value_out, vif.err_out);
        end
        drive('0, 7'h7f);
        vif.ack_in = 1'b1; step(); vif.ack_in = 1'b0;
        nvec++;
        if (vif.valid_out !== 1'b0 || vif.valid_out !== m_valid) begin
            nfail++;
            $display("FAIL basic_ack: valid=%b, expected 0", vif.valid_out);
        end
    endtask

    task automatic test_glitch();
        logic [3:0] v1;
        v1 = 4'($urandom);
        drive(2'b10, GLYPH[v1]);
        repeat (STABLE_CYC) step();
        drive(2'b01, GLYPH[5]);
        repeat (STABLE_CYC - 1) step();
        drive('0, 7'h7f);
        for (int c = 0; c < 6; c++) begin
            step();
            nvec++;
            if (vif.valid_out !== 1'b0 || vif.valid_out !== m_valid) begin
                nfail++;
                $display("FAIL glitch_nocommit c%0d: valid=%b, expected 0", c, vif.valid_out);
            end
        end
        drive(2'b01, GLYPH[5]);
        repeat (STABLE_CYC + 1) step();
        nvec++;
        if (vif.valid_out !== 1'b1 || vif.value_out !== {v1, 4'h5} || vif.err_out !== 2'b00) begin
            nfail++;
            $display("FAIL glitch_commit: value=%h err=%b valid=%b, expected %h 00 1",
                     vif.value_out, vif.err_out, vif.valid_out, {v1, 4'h5});
        end
        drive('0, 7'h7f);
        vif.ack_in = 1'b1; step(); vif.ack_in = 1'b0;
    endtask

    task automatic test_illegal();
        drive(2'b01, GLYPH[8]);
        repeat (STABLE_CYC) step();
        drive(2'b10, 7'b1111111);
        repeat (STABLE_CYC + 1) step();
        nvec++;
        if (vif.valid_out !== 1'b1 || vif.value_out !== 8'h08 || vif.err_out !== 2'b10) begin
            nfail++;
            $display("FAIL illegal_blank: value=%h err=%b valid=%b, expected 08 10 1",
                     vif.value_out, vif.err_out, vif.valid_out);
        end
        drive('0, 7'h7f);
        vif.ack_in = 1'b1; step(); vif.ack_in = 1'b0;
        drive(2'b11, GLYPH[$urandom_range(0, 15)]);
        for (int c = 0; c < 10; c++) begin
            step();
            nvec++;
            if (vif.valid_out !== 1'b0 || vif.valid_out !== m_valid) begin
                nfail++;
                $display("FAIL multihot c%0d: valid=%b, expected 0", c, vif.valid_out);
            end
        end
        drive('0, 7'h7f);
        step();
    endtask

    task automatic test_handshake();
        logic [3:0] a0, a1, b0, b1;
        logic [7:0] held;
        a0 = 4'($urandom); a1 = 4'($urandom);
        b0 = 4'($urandom); b1 = 4'($urandom);
        drive(2'b01, GLYPH[a0]);
        repeat (STABLE_CYC) step();
        drive(2'b10, GLYPH[a1]);
        repeat (STABLE_CYC + 1) step();
        held = {a1, a0};
        nvec++;
        if (vif.valid_out !== 1'b1 || vif.value_out !== held) begin
            nfail++;
            $display("FAIL hs_frame1: value=%h valid=%b, expected %h 1", vif.value_out, vif.valid_out, held);
        end
        for (int c = 0; c < 20; c++) begin
            drive(c < 10 ? 2'b01 : 2'b10, c < 10 ? GLYPH[b0] : GLYPH[b1]);
            step();
            nvec++;
            if (vif.valid_out !== 1'b1 || vif.value_out !== held || vif.value_out !== m_value) begin
                nfail++;
                $display("FAIL hs_hold c%0d: value=%h valid=%b, expected %h 1",
                         c, vif.value_out, vif.valid_out, held);
            end
        end
        vif.ack_in = 1'b1; step(); vif.ack_in = 1'b0;
        nvec++;
        if (vif.valid_out !== 1'b0) begin
            nfail++;
            $display("FAIL hs_ack: valid=%b, expected 0", vif.valid_out);
        end
        step();
        nvec++;
        if (vif.valid_out !== 1'b1 || vif.value_out !== {b1, b0} || vif.value_out !== m_value) begin
            nfail++;
            $display("FAIL hs_frame2: value=%h valid=%b, expected %h 1",
                     vif.value_out, vif.valid_out, {b1, b0});
        end
        drive('0, 7'h7f);
        vif.ack_in = 1'b1; step(); vif.ack_in = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] v1;
        v1 = 4'($urandom);
        drive(2'b01, GLYPH[10]);
        repeat (STABLE_CYC) step();
        rst = 1'b1; step(); rst = 1'b0;
        nvec++;
        if ({vif.value_out, vif.err_out, vif.valid_out} !== '0) begin
            nfail++;
            $display("FAIL rstmid_clear: value=%h err=%b valid=%b, expected 00 00 0",
                     vif.value_out, vif.err_out, vif.valid_out);
        end
        drive(2'b10, GLYPH[v1]);
        for (int c = 0; c < STABLE_CYC + 6; c++) begin
            step();
            nvec++;
            if (vif.valid_out !== 1'b0 || vif.valid_out !== m_valid) begin
                nfail++;
                $display("FAIL rstmid_partial c%0d: valid=%b, expected 0", c, vif.valid_out);
            end
        end
        drive(2'b01, GLYPH[10]);
        repeat (STABLE_CYC + 1) step();
        nvec++;
        if (vif.valid_out !== 1'b1 || vif.value_out !== {v1, 4'hA}) begin
            nfail++;
            $display("FAIL rstmid_recommit: value=%h valid=%b, expected %h 1",
                     vif.value_out, vif.valid_out, {v1, 4'hA});
        end
        drive('0, 7'h7f);
        vif.ack_in = 1'b1; step(); vif.ack_in = 1'b0;
    endtask

    task automatic test_random();
        logic [NDIG-1:0] sel;
        logic [6:0]      seg;
        int              len;
        for (int r = 0; r < 300; r++) begin
            sel = ($urandom_range(0, 7) == 0) ? NDIG'($urandom) : (($urandom & 1) ? 2'b01 : 2'b10);
            seg = ($urandom_range(0, 4) == 0) ? 7'($urandom) : GLYPH[$urandom_range(0, 15)];
            len = $urandom_range(1, 6);
            drive(sel, seg);
            for (int c = 0; c < len; c++) begin
                vif.ack_in = ($urandom_range(0, 3) == 0);
                rst        = ($urandom_range(0, 199) == 0);
                step();
                nvec++;
                if (vif.value_out !== m_value || vif.err_out !== m_err_out || vif.valid_out !== m_valid) begin
                    nfail++;
                    $display("FAIL random r%0d: value=%h err=%b valid=%b, expected %h %b %b",
                             r, vif.value_out, vif.err_out, vif.valid_out, m_value, m_err_out, m_valid);
                end
            end
        end
        rst = 1'b0;
        vif.ack_in = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        vif.ack_in = 1'b0;
        drive('0, 7'h7f);
        test_reset();
        test_basic_frame();
        test_glitch();
        test_illegal();
        test_handshake();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/seg7_capture.md
Name: seg7_capture

Overview:
Reader for a multiplexed DE2-style 7-segment display bus. It samples the active-low segment pattern and the one-hot digit select, and filters out glitches by requiring each pattern to be stable. It decodes each pattern back to a 4-bit hex nibble and assembles an NDIG-digit word. The word is presented with a valid/ack handshake, so adder results can be read back from a display driver for self-check and loopback tests.

Parameters:
NDIG, 2, number of display digits in a frame (digit 0 = least significant nibble).
STABLE_CYC, 4, consecutive identical samples required before a digit is committed (>=2).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
seg7_in  input  7  active-low segment pattern, bit0=a .. bit6=g.
dig_sel  input  NDIG  one-hot digit select, active-high.
ack_in  input  1  consumer accepts the presented word.
value_out  output  4*NDIG  assembled word; digit i occupies bits [4i+3:4i].
err_out  output  NDIG  per-digit flag: pattern was not a legal hex glyph.
valid_out  output  1  word on value_out/err_out is complete and held.

Behaviour:
- Reset values (synchronous, rst=1 at a rising edge):
  - value_out=0, err_out=0, valid_out=0.
  - State COLLECT, all captured bits 0, stability counter 0, sample register 0.
- Input sampling:
  - {dig_sel, seg7_in} is registered every cycle.
  - The counter increments (saturating at STABLE_CYC-1) when the new sample equals the previous one.
  - The counter clears to 0 on any difference.
- Commit:
  - Fires on the edge where the counter reaches STABLE_CYC-1, i.e. the same pair has been seen at STABLE_CYC consecutive edges, and dig_sel is one-hot.
  - Slot[i] is written with the decoded nibble, err[i] is written, and captured[i] is set.
  - A commit fires once per stable run; a new commit needs the input to change and restabilise.
- Illegal patterns: any pattern outside the 16 glyphs, including blank 7'b1111111, gives nibble 0 and err=1.
- dig_sel zero or multi-hot: never commits; the counter still tracks stability, but the commit is suppressed.
- Re-commit: a re-commit of an already captured digit while in COLLECT overwrites its slot (latest wins).
- Glyph table (hex -> pattern):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, B=0000011
  - C=1000110, D=0100001, E=0000110, F=0001110
- State machine:
  - COLLECT -> HOLD on the edge after captured becomes all ones.
    - On that edge: slots/errs are copied to value_out/err_out, valid_out=1, captured is cleared.
  - HOLD:
    - Outputs are frozen and valid_out stays 1.
    - Sampling and commits into the slots continue, building the next frame.
    - ack_in=1 -> COLLECT; valid_out=0 on that edge.
    - If captured is again all ones at the ack edge, go straight back to HOLD one cycle later with the new word.
  - ack_in in COLLECT is ignored.
- Simultaneous events:
  - A last-digit commit and an ack on the same edge are both honoured.
  - rst has priority over everything.
- Latency: from the first cycle of a stable pattern on the final digit to valid_out=1 is STABLE_CYC+1 edges (1 sample register + STABLE_CYC-1 counting + 1 transfer).
- Reset mid-frame discards partial captures; the first post-reset commit needs a full STABLE_CYC run.

Decomposition:
- Package seg7_pkg:
  - SEG_0..SEG_F glyph constants and SEG_BLANK.
  - State encoding (COLLECT, HOLD).
  - Counter width function clog2(STABLE_CYC).
- Sub-module seg7_to_binary: combinational pattern -> {invalid, nibble[3:0]}, one instance on the sample register.

Test Plan:
- Reset: assert rst 2 cycles with random inputs -> value_out=8'h00, err_out=2'b00, valid_out=0 throughout and one cycle after release.
- Basic frame:
  - Stimulus: dig_sel=01, seg7_in=0110000 for 4 cycles, then dig_sel=10, seg7_in=1111001 for 4 cycles.
  - Response: valid_out=1 exactly 5 edges after digit-1 data starts, value_out=8'h13, err_out=00.
- Glitch rejection: digit 0 pattern 0010010 held only 3 cycles then changed -> no commit, valid_out stays 0; held 4 cycles -> commit of 5.
- Illegal / select errors:
  - Blank 1111111 on digit 1 with 0000000 (8) on digit 0 -> value_out=8'h08, err_out=2'b10.
  - dig_sel=11 held 10 cycles -> no commit.
- Handshake:
  - Stimulus: after a valid frame, keep ack_in=0 for 20 cycles while new digits arrive.
  - Response: value_out/valid_out are unchanged throughout; ack_in=1 -> valid_out=0 next edge; the next frame's value then appears.
- Reset mid-operation: commit digit 0 (A=0001000), pulse rst, then commit only digit 1 -> valid_out stays 0 until digit 0 is recommitted.
